// File: rtl/alu.sv
// Registered 8-bit (parameterisable) integer ALU.
//
// Every rising clk edge computes one of eight operations on in_a/in_b, selected by
// opcode, and registers the result and status flags. Latency is one cycle and a new
// operation is accepted every cycle.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset; clears out and flags
//   in_a    - operand A
//   in_b    - operand B; low $clog2(WIDTH) bits are the shift amount for shifts
//   opcode  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 ASR
//   out     - registered result
//   flags   - registered status {V, C, Z}
module alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags
);

    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpShl = 3'b101,
        OpShr = 3'b110,
        OpAsr = 3'b111
    } op_e;

    op_e                   op;
    logic [ShW-1:0]        sh;
    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;
    logic [WIDTH:0]        shl_ext;
    logic [WIDTH:0]        shr_ext;
    logic signed [WIDTH:0] asr_ext;

    logic [WIDTH-1:0]      out_d, out_q;
    logic [2:0]            flags_d, flags_q;
    logic                  v_flag, c_flag;

    assign op = op_e'(opcode);
    assign sh = in_b[ShW-1:0];

    // Arithmetic at WIDTH+1 bits so bit WIDTH is the carry / borrow.
    assign sum  = {1'b0, in_a} + {1'b0, in_b};
    assign diff = {1'b0, in_a} - {1'b0, in_b};

    // Shifts carry one extra bit that catches the last bit shifted out; with sh == 0
    // that bit is the zero padding, so C is naturally 0.
    assign shl_ext = {1'b0, in_a} << sh;
    assign shr_ext = {in_a, 1'b0} >> sh;
    assign asr_ext = $signed({in_a, 1'b0}) >>> sh;

    always_comb begin
        out_d  = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        unique case (op)
            OpAdd: begin
                out_d  = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                         (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OpSub: begin
                out_d  = diff[WIDTH-1:0];
                c_flag = diff[WIDTH];
                v_flag = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                         (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OpAnd: out_d = in_a & in_b;
            OpOr:  out_d = in_a | in_b;
            OpXor: out_d = in_a ^ in_b;
            OpShl: begin
                out_d  = shl_ext[WIDTH-1:0];
                c_flag = shl_ext[WIDTH];
            end
            OpShr: begin
                out_d  = shr_ext[WIDTH:1];
                c_flag = shr_ext[0];
            end
            OpAsr: begin
                out_d  = asr_ext[WIDTH:1];
                c_flag = asr_ext[0];
            end
        endcase
        // Z reflects this cycle's result, not the previously registered one.
        flags_d = {v_flag, c_flag, (out_d == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out   = out_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] opcode;
    logic [7:0] out;
    logic [2:0] flags;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_a   (in_a),
        .in_b   (in_b),
        .opcode (opcode),
        .out    (out),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic definitions: returns {V, C, Z, result[7:0]}.
    function automatic logic [10:0] model(input int op, input int a, input int b);
        int  r, sa, sb, sr, sh;
        bit  c, v;
        logic [7:0] r8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        c  = 0;
        v  = 0;
        r  = 0;
        sr = 0;
        case (op)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127 || sr < -128); end
            1: begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127 || sr < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << sh;  c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
            6: begin r = a >> sh;  c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            default: begin r = sa >>> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
        endcase
        r  = r & 255;
        r8 = r[7:0];
        return {v, c, (r == 0), r8};
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp_out, input logic [2:0] exp_flags);
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", tag, out, exp_out);
        end
        checks++;
        assert (flags === exp_flags) else begin
            errors++;
            $error("FAIL %s flags: got %b expected %b", tag, flags, exp_flags);
        end
    endtask

    // Apply one operation, clock it, and compare against literal expectations.
    task automatic op_lit(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] eo, input logic [2:0] ef);
        opcode = op;
        in_a   = a;
        in_b   = b;
        @(posedge clk);
        #1;
        chk(tag, eo, ef);
    endtask

    // Apply one operation, clock it, and compare against the model.
    task automatic op_model(input string tag, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b);
        logic [10:0] e;
        e = model(int'(op), int'(a), int'(b));
        op_lit(tag, op, a, b, e[7:0], e[10:8]);
    endtask

    initial begin
        logic [10:0] prev;
        logic [10:0] e;
        logic [2:0]  rop;
        logic [7:0]  ra, rb;

        rst_n  = 1'b0;
        in_a   = 8'h00;
        in_b   = 8'h00;
        opcode = 3'b000;
        #2;
        chk("reset_initial", 8'h00, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_hold", 8'h00, 3'b000);

        // ADD
        op_lit("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 3'b011);
        op_lit("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 3'b100);
        // SUB
        op_lit("sub_03_05", 3'b001, 8'h03, 8'h05, 8'hFE, 3'b010);
        op_lit("sub_80_01", 3'b001, 8'h80, 8'h01, 8'h7F, 3'b100);
        op_lit("sub_eq",    3'b001, 8'h42, 8'h42, 8'h00, 3'b001);
        // Logic
        op_lit("and_f0_0f", 3'b010, 8'hF0, 8'h0F, 8'h00, 3'b001);
        op_lit("or_f0_0f",  3'b011, 8'hF0, 8'h0F, 8'hFF, 3'b000);
        op_lit("xor_aa_aa", 3'b100, 8'hAA, 8'hAA, 8'h00, 3'b001);
        // Shifts by 1, by 0, and by 9 (upper bits of b ignored)
        op_lit("shl_81_1",  3'b101, 8'h81, 8'h01, 8'h02, 3'b010);
        op_lit("shr_81_1",  3'b110, 8'h81, 8'h01, 8'h40, 3'b010);
        op_lit("asr_81_1",  3'b111, 8'h81, 8'h01, 8'hC0, 3'b010);
        op_lit("shl_81_0",  3'b101, 8'h81, 8'h00, 8'h81, 3'b000);
        op_lit("shr_81_0",  3'b110, 8'h81, 8'h00, 8'h81, 3'b000);
        op_lit("asr_81_0",  3'b111, 8'h81, 8'h00, 8'h81, 3'b000);
        op_lit("shl_81_9",  3'b101, 8'h81, 8'h09, 8'h02, 3'b010);
        op_lit("shr_81_9",  3'b110, 8'h81, 8'h09, 8'h40, 3'b010);
        op_lit("asr_81_9",  3'b111, 8'h81, 8'h09, 8'hC0, 3'b010);
        op_lit("shl_01_7",  3'b101, 8'h01, 8'h07, 8'h80, 3'b000);
        op_lit("shr_80_7",  3'b110, 8'h80, 8'h07, 8'h01, 3'b000);
        op_lit("asr_80_7",  3'b111, 8'h80, 8'h07, 8'hFF, 3'b000);
        op_lit("shl_80_1z", 3'b101, 8'h80, 8'h01, 8'h00, 3'b011);

        // Mid-stream reset: load 0x5A, then drop rst_n between edges.
        op_lit("pre_reset_5a", 3'b000, 8'h50, 8'h0A, 8'h5A, 3'b000);
        opcode = 3'b011;
        in_a   = 8'h33;
        in_b   = 8'h44;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", 8'h00, 3'b000);
        @(posedge clk);
        #1;
        chk("reset_held_1", 8'h00, 3'b000);
        @(posedge clk);
        #1;
        chk("reset_held_2", 8'h00, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_after_release", 8'h00, 3'b000);
        op_lit("post_reset_or", 3'b011, 8'h33, 8'h44, 8'h77, 3'b000);

        // Pipelined random stream: each cycle new inputs; before the edge the output
        // still holds the previous result, after the edge it holds the new one.
        prev = {3'b000, 8'h77};
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            if (i % 37 == 0) rb = 8'h00;
            opcode = rop;
            in_a   = ra;
            in_b   = rb;
            #1;
            chk("pipe_hold", prev[7:0], prev[10:8]);
            e = model(int'(rop), int'(ra), int'(rb));
            @(posedge clk);
            #1;
            chk("pipe_result", e[7:0], e[10:8]);
            prev = e;
        end

        // A few exhaustive-ish corners through the model.
        for (int op = 0; op < 8; op++) begin
            op_model("corner_00_00", 3'(op), 8'h00, 8'h00);
            op_model("corner_ff_ff", 3'(op), 8'hFF, 8'hFF);
            op_model("corner_80_7f", 3'(op), 8'h80, 8'h7F);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
